// File: rtl/tape_ser_pkg.sv
// Shared types for the tape-path serializer.
// Enum carries PAR even when PARITY_EN is off.
package tape_ser_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      PAR   = 2'd2
   } state_t;

   localparam logic LSB_FIRST = 1'b0;
   localparam logic MSB_FIRST = 1'b1;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load shift register with selectable output end.
// Direction is latched together with the word.
module piso_shift_reg
   import tape_ser_pkg::*;
#(
   parameter int w = 8
) (
   input  logic         clock,
   input  logic         reset_L,
   input  logic         load,
   input  logic         shift,
   input  logic         msb_first,
   input  logic [w-1:0] D,
   output logic [w-1:0] Q,
   output logic         serial
);

   logic dir;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         Q   <= '0;
         dir <= LSB_FIRST;
      end else if (load) begin
         Q   <= D;
         dir <= msb_first;
      end else if (shift) begin
         if (dir == MSB_FIRST)
            Q <= {Q[w-2:0], 1'b0};
         else
            Q <= {1'b0, Q[w-1:1]};
      end
   end

   assign serial = (dir == MSB_FIRST) ? Q[w-1] : Q[0];

endmodule

// File: rtl/tape_serializer.sv
// Tape word PISO transmitter with valid/ready on both sides.
// Optional trailing even-parity bit: define PARITY_EN.
module tape_serializer
   import tape_ser_pkg::*;
#(
   parameter int w = 8
) (
   input  logic         clock,
   input  logic         reset_L,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic [w-1:0] data_in,
   input  logic         msb_first,
   output logic         serial_out,
   output logic         serial_valid,
   input  logic         serial_ready,
   output logic         busy,
   output logic         done
);

   localparam int CW = $clog2(w + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(w);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   state_t         state;
   logic [CW-1:0]  cnt;
   logic           sv;
   logic           dn;
   logic [w-1:0]   unused_q;
   logic           sbit;
   logic           ld;
   logic           xfer;

   assign ld   = load_valid && (state == IDLE);
   assign xfer = sv && serial_ready;

   piso_shift_reg #(.w(w)) u_piso (
      .clock     (clock),
      .reset_L   (reset_L),
      .load      (ld),
      .shift     (xfer && (state == SHIFT)),
      .msb_first (msb_first),
      .D         (data_in),
      .Q         (unused_q),
      .serial    (sbit)
   );

`ifdef PARITY_EN
   logic par;

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L)
         par <= 1'b0;
      else if (ld)
         par <= ^data_in;
   end

   assign serial_out = sv & ((state == PAR) ? par : sbit);
`else
   assign serial_out = sv & sbit;
`endif

   always_ff @(posedge clock or negedge reset_L) begin
      if (!reset_L) begin
         state <= IDLE;
         cnt   <= '0;
         sv    <= 1'b0;
         dn    <= 1'b0;
      end else begin
         dn <= 1'b0;
         unique case (state)
            IDLE: begin
               if (ld) begin
                  cnt   <= CNT_FULL;
                  sv    <= 1'b1;
                  state <= SHIFT;
               end
            end
            SHIFT: begin
               if (xfer) begin
                  if (cnt == CNT_ONE) begin
`ifdef PARITY_EN
                     // hold count at 1 so it reads 0 only in IDLE
                     state <= PAR;
`else
                     cnt   <= '0;
                     sv    <= 1'b0;
                     dn    <= 1'b1;
                     state <= IDLE;
`endif
                  end else begin
                     cnt <= cnt - CNT_ONE;
                  end
               end
            end
`ifdef PARITY_EN
            PAR: begin
               if (xfer) begin
                  cnt   <= '0;
                  sv    <= 1'b0;
                  dn    <= 1'b1;
                  state <= IDLE;
               end
            end
`endif
            default: begin
               cnt   <= '0;
               sv    <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign serial_valid = sv;
   assign done         = dn;
   assign busy         = (state != IDLE);
   assign load_ready   = (state == IDLE);

endmodule

// File: tb/tb_tape_serializer.sv
// Self-checking bench for tape_serializer.
// Table vectors, hand sequences and random frames.
module tb_tape_serializer;

   localparam int W = 8;
`ifdef PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif
   localparam int FL = W + PB;

   logic         clock = 1'b0;
   logic         reset_L = 1'b0;
   logic         load_valid = 1'b0;
   logic         load_ready;
   logic [W-1:0] data_in = '0;
   logic         msb_first = 1'b0;
   logic         serial_out;
   logic         serial_valid;
   logic         serial_ready = 1'b0;
   logic         busy;
   logic         done;

   int checks = 0;
   int failures = 0;

   tape_serializer #(.w(W)) dut (
      .clock        (clock),
      .reset_L      (reset_L),
      .load_valid   (load_valid),
      .load_ready   (load_ready),
      .data_in      (data_in),
      .msb_first    (msb_first),
      .serial_out   (serial_out),
      .serial_valid (serial_valid),
      .serial_ready (serial_ready),
      .busy         (busy),
      .done         (done)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [W-1:0] d;
      logic         m;
      logic [W-1:0] stream;
      logic         par;
      int           sb;
      int           sn;
      int           inj;
      int           dc;
   } vec_t;

   vec_t vt[$];

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Bit i of the result is the i-th bit on the wire.
   function automatic logic [W-1:0] wire_order(input logic [W-1:0] d,
                                               input logic m);
      logic [W-1:0] s;
      for (int i = 0; i < W; i++)
         s[i] = m ? d[W-1-i] : d[i];
      return s;
   endfunction

   task automatic frame(input logic [W-1:0] d, input logic m,
                        input logic [W-1:0] stream, input logic par,
                        input int sb, input int sn, input int inj,
                        input logic rnd, input int dc);
      int   cyc;
      int   k;
      int   st;
      int   ns;
      int   exp_dc;
      logic rdy;
      logic eb;
      chk("load_ready_idle", 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      data_in    = d;
      msb_first  = m;
      serial_ready = 1'b1;
      @(negedge clock);
      load_valid = 1'b0;
      data_in    = W'($urandom);
      msb_first  = 1'($urandom);
      cyc = 1;
      k   = 0;
      st  = 0;
      ns  = 0;
      while (k < FL && cyc < 300) begin
         eb = (k < W) ? stream[k] : par;
         if (k == sb && st < sn) begin
            rdy = 1'b0;
            st++;
         end else if (rnd) begin
            rdy = 1'($urandom_range(0, 1));
         end else begin
            rdy = 1'b1;
         end
         if (!rdy) ns++;
         serial_ready = rdy;
         if (cyc == inj) begin
            load_valid = 1'b1;
            data_in    = ~d;
            msb_first  = ~m;
         end
         chk("serial_valid", 32'(serial_valid), 32'd1);
         chk("serial_out", 32'(serial_out), 32'(eb));
         chk("busy", 32'(busy), 32'd1);
         chk("load_ready_busy", 32'(load_ready), 32'd0);
         chk("done_early", 32'(done), 32'd0);
         @(negedge clock);
         load_valid = 1'b0;
         if (rdy) k++;
         cyc++;
      end
      if (k < FL) begin
         checks++;
         failures++;
         $display("FAIL frame_timeout actual=%0d expected=%0d", k, FL);
      end
      exp_dc = (dc < 0) ? (FL + 1 + ns) : dc;
      chk("done_cycle", 32'(cyc), 32'(exp_dc));
      chk("done", 32'(done), 32'd1);
      chk("load_ready_done", 32'(load_ready), 32'd1);
      chk("serial_valid_done", 32'(serial_valid), 32'd0);
      chk("serial_out_done", 32'(serial_out), 32'd0);
      chk("busy_done", 32'(busy), 32'd0);
   endtask

   task automatic idle_cycle();
      serial_ready = 1'($urandom);
      @(negedge clock);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_load_ready", 32'(load_ready), 32'd1);
      chk("idle_serial_valid", 32'(serial_valid), 32'd0);
      chk("idle_serial_out", 32'(serial_out), 32'd0);
   endtask

   initial begin
      vt.push_back('{8'hC1, 1'b0, 8'hC1, 1'b1, -1, 0, 3, FL + 1});
      vt.push_back('{8'hC1, 1'b1, 8'h83, 1'b1, -1, 0, 0, FL + 1});
      vt.push_back('{8'h01, 1'b1, 8'h80, 1'b1, -1, 0, 0, FL + 1});
      vt.push_back('{8'hA5, 1'b0, 8'hA5, 1'b0, 2, 3, 0, FL + 4});
      vt.push_back('{8'h0F, 1'b1, 8'hF0, 1'b0, -1, 0, 5, FL + 1});
      vt.push_back('{8'h80, 1'b0, 8'h80, 1'b1, 7, 1, 0, FL + 2});
`ifdef PARITY_EN
      vt.push_back('{8'h07, 1'b0, 8'h07, 1'b1, -1, 0, 0, 10});
      vt.push_back('{8'h03, 1'b0, 8'h03, 1'b0, -1, 0, 0, 10});
      vt.push_back('{8'h07, 1'b0, 8'h07, 1'b1, 8, 2, 0, 12});
`endif

      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_serial_valid", 32'(serial_valid), 32'd0);
      chk("rst_serial_out", 32'(serial_out), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      reset_L = 1'b1;
      @(negedge clock);
      chk("rel_load_ready", 32'(load_ready), 32'd1);
      chk("rel_serial_valid", 32'(serial_valid), 32'd0);
      chk("rel_done", 32'(done), 32'd0);

      foreach (vt[i]) begin
         frame(vt[i].d, vt[i].m, vt[i].stream, vt[i].par,
               vt[i].sb, vt[i].sn, vt[i].inj, 1'b0, vt[i].dc);
         // entry 1 runs straight into entry 2 from its done cycle
         if (i != 1) idle_cycle();
      end

      load_valid = 1'b1;
      data_in    = 8'hA5;
      msb_first  = 1'b0;
      serial_ready = 1'b1;
      @(negedge clock);
      load_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("pre_rst_bit", 32'(serial_out), 32'(data_in[i]));
         @(negedge clock);
      end
      chk("pre_rst_valid", 32'(serial_valid), 32'd1);
      reset_L = 1'b0;
      #1;
      chk("async_serial_valid", 32'(serial_valid), 32'd0);
      chk("async_serial_out", 32'(serial_out), 32'd0);
      chk("async_busy", 32'(busy), 32'd0);
      chk("async_done", 32'(done), 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset_L = 1'b1;
      @(negedge clock);
      frame(8'h0F, 1'b0, 8'h0F, 1'b0, -1, 0, 0, 1'b0, FL + 1);
      idle_cycle();

      for (int n = 0; n < 30; n++) begin
         logic [W-1:0] d;
         logic         m;
         d = W'($urandom);
         m = 1'($urandom);
         frame(d, m, wire_order(d, m), ^d, -1, 0,
               int'($urandom_range(0, 6)), 1'b1, -1);
         repeat ($urandom_range(0, 2)) idle_cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/tape_serializer.md
Name: tape_serializer

Overview:
Parallel-in, serial-out transmitter for the Turing machine tape path. It is the sending end of the serial bit stream that the tape-side SIPO shift register consumes.
- Accepts a w-bit tape word through a valid/ready load handshake.
- Shifts the word out one bit per accepted transfer, LSB-first or MSB-first, with downstream backpressure.
- Pulses done when the frame completes.

Parameters:
w, 8, tape word width in bits; must be >= 2.

Ports:
clock  input  1  system clock; all state changes on posedge.
reset_L  input  1  asynchronous reset, active low.
load_valid  input  1  data_in and msb_first are valid.
load_ready  output  1  block can accept a word (IDLE).
data_in  input  w  parallel word to transmit.
msb_first  input  1  sampled at load; 1 = bit w-1 first, 0 = bit 0 first.
serial_out  output  1  current serial bit.
serial_valid  output  1  serial_out holds a valid bit.
serial_ready  input  1  downstream accepts the bit this cycle.
busy  output  1  frame in progress (not IDLE).
done  output  1  one-cycle pulse after the final bit is accepted.

Behaviour:
- Reset (reset_L=0, asynchronous): state=IDLE, shift register=0, bit counter=0, serial_out=0, serial_valid=0, done=0, busy=0, load_ready=1 after release. A reset mid-frame abandons the frame; serial_valid drops immediately, without waiting for a clock edge.
- States: IDLE, SHIFT, plus PAR when PARITY_EN is defined. The state enum is held in the package.
- IDLE:
  - load_ready=1.
  - On load_valid&&load_ready: capture data_in and msb_first, set counter=w, go to SHIFT.
  - Latency: serial_valid=1 in the cycle after the load handshake.
  - load_valid outside IDLE is ignored, with no effect.
- SHIFT:
  - serial_valid=1.
  - serial_out = Q[w-1] if msb_first, else Q[0].
  - Transfer occurs on serial_valid&&serial_ready: shift toward the output end (fill with 0) and decrement the counter.
  - While serial_ready=0: serial_out and the counter are held stable; no bit is lost or repeated.
  - On the transfer with counter==1: go to PAR if PARITY_EN is defined, otherwise go to IDLE and assert done for the next cycle.
- done:
  - Registered; high exactly one cycle, coincident with the first IDLE cycle.
  - load_ready is also 1 in that cycle, so a back-to-back load is legal. The next frame's first bit appears one cycle later, so the gap between frames is one bubble cycle minimum.
- serial_out=0 whenever serial_valid=0.
- busy = (state != IDLE).
- Counter width: $clog2(w+1); never wraps. The counter is 0 only in IDLE.

Optional Feature:
Macro PARITY_EN.
- Defined: after the w data bits, state PAR drives serial_out = even parity (XOR of the loaded word, captured at load) with serial_valid=1, obeying the same serial_ready backpressure. Its transfer returns to IDLE and pulses done. A frame is w+1 bits.
- Undefined: the PAR state and parity register do not exist. A frame is w bits.

Decomposition:
- Package tape_ser_pkg: state enum typedef (IDLE, SHIFT, PAR) and the direction constants LSB_FIRST=1'b0, MSB_FIRST=1'b1.
- Sub-module piso_shift_reg (parameter w):
  - Inputs: load, shift, msb_first, D.
  - Outputs: Q and serial bit.
  - Uses the same asynchronous active-low reset.
- The top level holds the FSM, bit counter, done register and parity.

Test Plan:
1. Reset: hold reset_L=0 across clock edges, then release -> serial_valid=0, serial_out=0, done=0, busy=0, load_ready=1. Pulse load_valid with load_ready low mid-frame -> ignored.
2. w=8, load 8'hC1, msb_first=0, serial_ready=1 -> serial_out 1,0,0,0,0,0,1,1 on cycles 1-8 after load; done=1 and load_ready=1 on cycle 9.
3. Load 8'hC1, msb_first=1 -> bits 1,1,0,0,0,0,0,1. Back-to-back load 8'h01 in the done cycle -> its first bit (0) appears one cycle later.
4. Backpressure: load 8'hA5 LSB-first, drop serial_ready for 3 cycles while bit 2 (value 1) is presented -> serial_out stays 1, serial_valid stays 1, and done lands at cycle 12 instead of 9.
5. Assert reset_L=0 after 4 bits are accepted -> serial_valid=0 before the next edge. After release, load 8'h0F LSB-first -> 1,1,1,1,0,0,0,0 and done at cycle 9.
6. PARITY_EN defined, LSB-first:
   - Load 8'h07 -> 9th bit=1, done at cycle 10.
   - Load 8'h03 -> 9th bit=0.
   - Stall serial_ready on the parity bit for 2 cycles -> parity held, done at cycle 12.
